// File: rtl/mem_access_unit.sv
// MEM-stage data-memory initiator: byte/half/word loads and stores with read-modify-write and load extension.
// Optional build macro STORE_FORWARD_EN keeps the last written word so that matching accesses skip the memory read.
module mem_access_unit #(
  parameter int LATENCY = 1,
  parameter int ADDR_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inMemRead,
  input  logic              inMemWrite,
  input  logic [ADDR_W-1:0] inAddress,
  input  logic [31:0]       inWriteData,
  input  logic [1:0]        inSize,
  input  logic              inUnsigned,
  output logic              outStall,
  output logic              outValid,
  output logic [31:0]       outReadData,
  output logic              outAddrError,
  output logic [1:0]        outReadWrite,
  output logic [31:0]       outMemAddress,
  output logic [31:0]       outMemWriteData,
  input  logic [31:0]       inMemData
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2,
    S_RESP = 2'd3
  } state_t;

  localparam logic [1:0] RW_IDLE  = 2'b00;
  localparam logic [1:0] RW_READ  = 2'b10;
  localparam logic [1:0] RW_WRITE = 2'b01;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [1:0]  r_addr_lo;
  logic [1:0]  r_size;
  logic        r_unsigned;
  logic        r_is_load;
  logic [31:0] r_wdata;
  logic [2:0]  r_cnt;
  logic [1:0]  r_rw;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_wdata;
  logic [31:0] r_rdata;
  logic        r_valid;
  logic        r_err;

  logic        w_req;
  logic        w_err;
  logic        w_cap;
  logic        w_stall;
  logic        w_fwd_hit;
  logic [31:0] w_fwd_data;
  logic [31:0] w_word_addr;
  logic [2:0]  w_cnt_nxt;
  logic [1:0]  w_rw_nxt;
  logic [31:0] w_mem_addr_nxt;
  logic [31:0] w_mem_wdata_nxt;
  logic [31:0] w_rdata_nxt;
  logic        w_valid_nxt;
  logic        w_err_nxt;

  // Little-endian lane select followed by sign or zero extension.
  function automatic logic [31:0] lane_extract(input logic [31:0] word, input logic [1:0] lo,
                                               input logic [1:0] size, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    case (lo)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      2'd3:    b = word[31:24];
      default: b = 8'd0;
    endcase
    h = lo[1] ? word[31:16] : word[15:0];
    case (size)
      2'b00:   res = {{24{~uns & b[7]}}, b};
      2'b01:   res = {{16{~uns & h[15]}}, h};
      default: res = word;
    endcase
    return res;
  endfunction

  // Replace the addressed lane of a memory word with right-justified store data.
  function automatic logic [31:0] lane_merge(input logic [31:0] word, input logic [31:0] data,
                                             input logic [1:0] lo, input logic [1:0] size);
    logic [31:0] res;
    case (size)
      2'b00: begin
        case (lo)
          2'd0:    res = {word[31:8], data[7:0]};
          2'd1:    res = {word[31:16], data[7:0], word[7:0]};
          2'd2:    res = {word[31:24], data[7:0], word[15:0]};
          2'd3:    res = {data[7:0], word[23:0]};
          default: res = word;
        endcase
      end
      2'b01:   res = lo[1] ? {data[15:0], word[15:0]} : {word[31:16], data[15:0]};
      default: res = data;
    endcase
    return res;
  endfunction

  assign w_req       = inMemRead | inMemWrite;
  assign w_word_addr = 32'(inAddress[ADDR_W-1:2]);
  assign w_err       = (inMemRead & inMemWrite) | (inSize == 2'b11) |
                       ((inSize == 2'b01) & inAddress[0]) |
                       ((inSize == 2'b10) & (inAddress[1:0] != 2'b00));

`ifdef STORE_FORWARD_EN
  logic        r_fwd_valid;
  logic [31:0] r_fwd_addr;
  logic [31:0] r_fwd_data;

  // Remember the word issued by the most recent memory write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fwd_valid <= 1'b0;
      r_fwd_addr  <= 32'd0;
      r_fwd_data  <= 32'd0;
    end else if (r_state == S_WR) begin
      r_fwd_valid <= 1'b1;
      r_fwd_addr  <= r_mem_addr;
      r_fwd_data  <= r_mem_wdata;
    end
  end

  assign w_fwd_hit  = r_fwd_valid & (r_fwd_addr == w_word_addr);
  assign w_fwd_data = r_fwd_data;
`else
  assign w_fwd_hit  = 1'b0;
  assign w_fwd_data = 32'd0;
`endif

  // Next-state and next-output decode.
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_rw_nxt        = r_rw;
    w_mem_addr_nxt  = r_mem_addr;
    w_mem_wdata_nxt = r_mem_wdata;
    w_rdata_nxt     = r_rdata;
    w_valid_nxt     = 1'b0;
    w_err_nxt       = 1'b0;
    w_cap           = 1'b0;
    w_stall         = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_stall = w_req;
        if (w_req) begin
          w_cap          = 1'b1;
          w_mem_addr_nxt = w_word_addr;
          if (w_err) begin
            w_state_nxt = S_RESP;
            w_rw_nxt    = RW_IDLE;
            w_valid_nxt = 1'b1;
            w_err_nxt   = 1'b1;
          end else if (inMemRead) begin
            if (w_fwd_hit) begin
              w_state_nxt = S_RESP;
              w_rw_nxt    = RW_IDLE;
              w_valid_nxt = 1'b1;
              w_rdata_nxt = lane_extract(w_fwd_data, inAddress[1:0], inSize, inUnsigned);
            end else begin
              w_state_nxt = S_RD;
              w_rw_nxt    = RW_READ;
              w_cnt_nxt   = 3'(LATENCY);
            end
          end else if (inSize == 2'b10) begin
            w_state_nxt     = S_WR;
            w_rw_nxt        = RW_WRITE;
            w_mem_wdata_nxt = inWriteData;
          end else if (w_fwd_hit) begin
            w_state_nxt     = S_WR;
            w_rw_nxt        = RW_WRITE;
            w_mem_wdata_nxt = lane_merge(w_fwd_data, inWriteData, inAddress[1:0], inSize);
          end else begin
            w_state_nxt = S_RD;
            w_rw_nxt    = RW_READ;
            w_cnt_nxt   = 3'(LATENCY);
          end
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_RD: begin
        w_stall   = 1'b1;
        w_cnt_nxt = r_cnt - 3'd1;
        // The memory word is valid in the last counted cycle.
        if (r_cnt == 3'd1) begin
          if (r_is_load) begin
            w_state_nxt = S_RESP;
            w_rw_nxt    = RW_IDLE;
            w_valid_nxt = 1'b1;
            w_rdata_nxt = lane_extract(inMemData, r_addr_lo, r_size, r_unsigned);
          end else begin
            w_state_nxt     = S_WR;
            w_rw_nxt        = RW_WRITE;
            w_mem_wdata_nxt = lane_merge(inMemData, r_wdata, r_addr_lo, r_size);
          end
        end else begin
          w_state_nxt = S_RD;
        end
      end
      S_WR: begin
        w_stall     = 1'b1;
        w_state_nxt = S_RESP;
        w_rw_nxt    = RW_IDLE;
        w_valid_nxt = 1'b1;
      end
      S_RESP: begin
        w_state_nxt = S_IDLE;
        w_rw_nxt    = RW_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_rw_nxt    = RW_IDLE;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= 3'd0;
      r_rw        <= RW_IDLE;
      r_mem_addr  <= 32'd0;
      r_mem_wdata <= 32'd0;
      r_rdata     <= 32'd0;
      r_valid     <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_rw        <= w_rw_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_mem_wdata <= w_mem_wdata_nxt;
      r_rdata     <= w_rdata_nxt;
      r_valid     <= w_valid_nxt;
      r_err       <= w_err_nxt;
    end
  end

  // Request attributes held for the whole access.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_addr_lo  <= 2'd0;
      r_size     <= 2'd0;
      r_unsigned <= 1'b0;
      r_is_load  <= 1'b0;
      r_wdata    <= 32'd0;
    end else if (w_cap) begin
      r_addr_lo  <= inAddress[1:0];
      r_size     <= inSize;
      r_unsigned <= inUnsigned;
      r_is_load  <= inMemRead;
      r_wdata    <= inWriteData;
    end
  end

  assign outStall        = w_stall;
  assign outValid        = r_valid;
  assign outReadData     = r_rdata;
  assign outAddrError    = r_err;
  assign outReadWrite    = r_rw;
  assign outMemAddress   = r_mem_addr;
  assign outMemWriteData = r_mem_wdata;

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Initiator side of the data-memory interface; sits in the MEM stage of the pipeline, between the EX/MEM register and the word-addressed data memory.
- Translates pipeline load/store requests (byte, half, word; signed/unsigned) into memory read/write commands on the `read_write` bus (2'b10 read, 2'b01 write, 2'b00 idle).
- Performs read-modify-write for sub-word stores and sign/zero extension for loads.
- Stalls the pipeline until each access completes.

Parameters:
- LATENCY, 1, clk cycles from read command asserted to inMemData valid (1..7).
- ADDR_W, 32, byte-address width from pipeline.

Ports:
- clk  in  1  clock; all state on posedge.
- rst  in  1  asynchronous reset, active-low (asserted at 0).
- inMemRead  in  1  load request.
- inMemWrite  in  1  store request.
- inAddress  in  ADDR_W  byte address.
- inWriteData  in  32  store data, right-justified.
- inSize  in  2  00 byte, 01 half, 10 word, 11 illegal.
- inUnsigned  in  1  zero-extend loads when 1.
- outStall  out  1  hold pipeline.
- outValid  out  1  one-cycle completion pulse.
- outReadData  out  32  extended load result.
- outAddrError  out  1  one-cycle misalignment/illegal pulse.
- outReadWrite  out  2  memory command.
- outMemAddress  out  32  word address = {2'b00, inAddress[31:2]}.
- outMemWriteData  out  32  word written to memory.
- inMemData  in  32  word returned by memory.

Behaviour:
- Reset (rst=0, async): state=IDLE, outReadWrite=00, outMemAddress=0, outMemWriteData=0, outReadData=0, outValid=0, outAddrError=0, latency counter=0.
- States: IDLE, RD, WR, RESP.
- IDLE:
  - Request = inMemRead|inMemWrite. outStall is combinationally 1 while a request is present.
  - On the clock edge, capture address, data, size and unsigned.
  - Error if: both inMemRead and inMemWrite are 1; inSize=11; half with addr[0]=1; word with addr[1:0]!=0.
  - On error: go to RESP with outAddrError=1, no memory command, outReadData unchanged.
  - Load, or sub-word store: go to RD, outReadWrite=10, counter=LATENCY.
  - Word store: go to WR, outReadWrite=01, outMemWriteData=inWriteData.
- RD:
  - outReadWrite held at 10; counter decrements each cycle.
  - At counter==1, sample inMemData.
  - Load: go to RESP, outReadData = selected lane extended.
  - Store: go to WR, outMemWriteData = sampled word with the target lane replaced.
- WR: outReadWrite=01 for exactly one cycle, then go to RESP.
- RESP:
  - outReadWrite=00, outValid=1, outStall=0.
  - Next state IDLE. A new request can be accepted on the following cycle, never in RESP itself.
- Lane selection is little-endian:
  - byte k = bits [8k+7:8k], with k=addr[1:0];
  - half at addr[1]=0 → [15:0], addr[1]=1 → [31:16].
- Extension: signed loads replicate the lane MSB; unsigned loads fill with zeros.
- Latencies (cycles with outStall=1):
  - load: LATENCY+1;
  - word store: 2;
  - sub-word store: LATENCY+2;
  - error: 1.
- Request inputs are ignored outside IDLE; captured values are used throughout the access.
- Reset mid-access: aborts immediately; outReadWrite=00 asynchronously; no partial write is issued.

Optional Feature:
- Macro: STORE_FORWARD_EN.
- When defined:
  - The unit keeps the last written word and its word address (valid bit cleared on reset).
  - A load whose word address matches skips RD: IDLE→RESP with data from the held word, so outStall=1 for 1 cycle.
  - A sub-word store with a match also skips RD: IDLE→WR, merging into the held word.
- When undefined: every load and sub-word store reads memory, with no extra registers.

Test Plan:
- LATENCY=1; word store 0xDEADBEEF @0x8, then word load @0x8 → outMemAddress=2, outReadWrite sequence 01,00,10,00; outReadData=0xDEADBEEF; outValid pulses twice.
- Memory word@0x4 = 0x11223344; byte store 0xAA @0x6 → read 10, then write 01 with outMemWriteData=0x11AA3344; stall for 3 cycles.
- Word@0 = 0x0000F080:
  - signed byte load @0x0 → 0xFFFFFF80;
  - unsigned byte load @0x1 → 0x000000F0;
  - signed half load @0x0 → 0xFFFFF080.
- Half load @0x3, word store @0x2, and inMemRead=inMemWrite=1 → outAddrError pulses each time; outReadWrite stays 00; 1-cycle stall.
- rst driven low during RD of a sub-word store → outReadWrite=00 immediately, no 01 cycle; after release the unit is in IDLE and memory is unchanged.
- STORE_FORWARD_EN defined: word store 0x12345678 @0x10, then load @0x10 → outReadWrite never 10; result 0x12345678 after 1 stall cycle.
